cp0_exc_ctrl: RTL
=================

# cp0_exc_ctrl

Coprocessor-0 exception/interrupt controller for the five-stage MIPS32 pipeline. It takes the 5-bit exception code carried into the M stage and the six hardware interrupt lines, and picks at most one trap per cycle. It maintains SR, Cause, EPC and PRId, sequences handler entry and `eret` return through a small state machine, and tells the pipeline when to flush and where to redirect the PC.

## Interface
- `HANDLER_ADDR`, 32'h0000_4180, PC loaded on exception/interrupt entry
- `PRID_VAL`, 32'h4D49_5053, read-only PRId contents
- `clk`  in  1  pipeline clock
- `reset`  in  1  asynchronous, active-high reset
- `pc_m`  in  32  PC of the M-stage instruction
- `bd_m`  in  1  M-stage instruction sits in a branch delay slot
- `exc_code_m`  in  5  exception code `[6:2]` piped to M; 0 = none
- `eret_m`  in  1  M-stage instruction is `eret`
- `hwint`  in  6  external interrupt requests `HWInt[7:2]`
- `cp0_we`  in  1  `mtc0` write strobe (M stage)
- `cp0_addr`  in  5  CP0 register number for read and write
- `cp0_wdata`  in  32  `mtc0` data
- `cp0_rdata`  out  32  `mfc0` data (combinational from `cp0_addr`)
- `flush`  out  1  kill F/D/E/M instructions this cycle
- `redirect`  out  1  load `redirect_pc` into PC at next edge
- `redirect_pc`  out  32  handler address or EPC
- `epc_out`  out  32  current EPC

## Operation
- Registers:
  - SR (12): IM[15:10], EXL[1], IE[0]; other bits read 0.
  - Cause (13): BD[31], IP[15:10], ExcCode[6:2]; read-only to software.
  - EPC (14): bits[1:0] always 0.
  - PRId (15): returns `PRID_VAL`.
  - All other addresses read 0.
- Cause.IP samples `hwint` every cycle.
- States:
  - RUN: EXL=0.
  - HANDLER: EXL=1.
  - RETURN: one cycle after `eret`, with EXL=0.
- `int_pend` = IE & !EXL & |(hwint & IM).
- In RUN:
  - If `int_pend`, take an interrupt with ExcCode 0. Interrupt beats a simultaneous nonzero `exc_code_m`.
  - Else if `exc_code_m`≠0, take that code.
- On a take: `flush`=`redirect`=1 and `redirect_pc`=`HANDLER_ADDR` in the same cycle. At the edge:
  - EPC is captured.
  - Cause.ExcCode and Cause.BD are captured.
  - EXL is set to 1 and the state moves to HANDLER.
- In HANDLER:
  - Interrupts are masked.
  - A nonzero `exc_code_m` still redirects to `HANDLER_ADDR` and updates ExcCode.
  - EPC and BD are held.
- `eret_m` in HANDLER (with no nonzero `exc_code_m`): `flush`=`redirect`=1, `redirect_pc`=EPC. EXL clears and the state moves to RETURN.
- `eret_m` in RUN: redirects to EPC and the state stays RUN.
- RETURN: no trap is taken, even if `int_pend`. After one cycle the state moves to RUN.
- `mtc0` to SR writes IM/EXL/IE. Writing EXL=1 moves the state to HANDLER; writing EXL=0 moves it to RUN.
- `mtc0` to EPC writes `cp0_wdata` & ~3.
- Simultaneous events:
  - trap vs `cp0_we`: the trap wins and the write is dropped.
  - `exc_code_m` vs `eret_m` in HANDLER: the exception wins.

## Timing
- Trap detection and `flush`/`redirect` are combinational, 0-cycle latency from inputs.
- Register updates land on the next rising edge. `mfc0` of the same register in the following cycle returns the new value.
- `hwint` → Cause.IP: 1 cycle. `hwint` → trap: same cycle, because the comparison uses live `hwint`.
- Reset, asynchronous:
  - SR, Cause and EPC = 0.
  - State = RUN.
  - `flush`=`redirect`=0 and `redirect_pc`=0 (IE=0 keeps interrupts off).
- Reset mid-HANDLER: returns to RUN immediately with EXL=0 and no redirect.

## Configuration
- `CP0_BD_EN` defined:
  - Cause.BD = `bd_m` at trap.
  - EPC = `bd_m` ? `pc_m`−4 : `pc_m`.
- `CP0_BD_EN` undefined:
  - Cause.BD is tied to 0.
  - EPC = `pc_m` always, and `bd_m` is ignored.

## Test plan
- Reset, then read SR/Cause/EPC/PRId:
  - SR/Cause/EPC return 0; PRId returns 32'h4D49_5053.
  - `flush`=0.
- `mtc0` SR=32'h0000_0401, then `hwint`=6'b000001 with `pc_m`=32'h3010:
  - same cycle: `redirect_pc`=32'h4180, `flush`=1;
  - next cycle: EPC=32'h3010, ExcCode=0, EXL=1.
- `exc_code_m`=5'd12 (Ov), `bd_m`=1, `pc_m`=32'h3024:
  - with `CP0_BD_EN`: EPC=32'h3020, BD=1;
  - without: EPC=32'h3024, BD=0.
- In HANDLER, `eret_m`=1 with EPC=32'h3020:
  - `redirect_pc`=32'h3020;
  - next cycle: state RETURN;
  - a pending interrupt is not taken until the cycle after.
- Interrupt and `exc_code_m`=5'd4 in the same cycle: ExcCode=0. A `cp0_we` to EPC in that cycle is dropped.
- Assert `reset` while in HANDLER: state is RUN and EXL=0 immediately; `redirect`=0.

Source files
------------

// File: rtl/cp0_exc_ctrl.sv
// cp0_exc_ctrl: Coprocessor-0 exception/interrupt controller for the
// five-stage MIPS32 pipeline. Chooses at most one trap per cycle, holds
// SR/Cause/EPC/PRId, sequences handler entry and eret return, and drives
// the pipeline flush/redirect.
// Optional feature macro: CP0_BD_EN (branch-delay-slot aware EPC and Cause.BD).
module cp0_exc_ctrl #(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
  parameter logic [31:0] PRID_VAL     = 32'h4D49_5053
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_m,
  input  logic        bd_m,
  input  logic [4:0]  exc_code_m,
  input  logic        eret_m,
  input  logic [5:0]  hwint,
  input  logic        cp0_we,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  output logic [31:0] cp0_rdata,
  output logic        flush,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic [31:0] epc_out
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_HANDLER,
    ST_RETURN
  } state_t;

  state_t      r_state;
  logic [5:0]  r_im;
  logic        r_ie;
  logic [5:0]  r_ip;
  logic [4:0]  r_exccode;
  logic        r_bd;
  logic [31:0] r_epc;

  logic        w_exl;
  logic        w_intPend;
  logic        w_takeInt;
  logic        w_takeExc;
  logic        w_trap;
  logic        w_eret;
  logic [31:0] w_epcCapture;
  logic        w_bdCapture;
  logic        w_unused;

  // EXL is simply "we are inside the handler"; the RETURN cycle reports EXL=0
  // but still refuses to take a trap so the returning instruction can issue.
  always_comb begin
    w_exl     = (r_state == ST_HANDLER);
    w_intPend = r_ie & ~w_exl & (|(hwint & r_im));
    w_takeInt = (r_state == ST_RUN) & w_intPend;
    w_takeExc = ((r_state == ST_RUN) & ~w_intPend & (exc_code_m != 5'd0)) |
                ((r_state == ST_HANDLER) & (exc_code_m != 5'd0));
    w_trap    = w_takeInt | w_takeExc;
    w_eret    = eret_m & ~w_trap;
  end

`ifdef CP0_BD_EN
  // A trapped delay-slot instruction restarts at its branch, one word back.
  always_comb begin
    w_bdCapture  = bd_m;
    w_epcCapture = bd_m ? (pc_m - 32'd4) : pc_m;
    w_unused     = &{1'b0, cp0_wdata[31:16], cp0_wdata[9:2]};
  end
`else
  // Without delay-slot tracking the faulting PC is always the restart point.
  always_comb begin
    w_bdCapture  = 1'b0;
    w_epcCapture = pc_m;
    w_unused     = &{1'b0, bd_m, cp0_wdata[31:16], cp0_wdata[9:2]};
  end
`endif

  // Pipeline control is combinational so the trap redirects in the same cycle;
  // reset forces it quiet even if the M stage still shows a trapping instruction.
  always_comb begin
    flush       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    if (!reset) begin
      if (w_trap) begin
        flush       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = HANDLER_ADDR;
      end else if (w_eret) begin
        flush       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = r_epc;
      end
    end
  end

  // mfc0 read mux; unimplemented register numbers read as zero.
  always_comb begin
    cp0_rdata = 32'd0;
    case (cp0_addr)
      5'd12:   cp0_rdata = {16'd0, r_im, 8'd0, w_exl, r_ie};
      5'd13:   cp0_rdata = {r_bd, 15'd0, r_ip, 3'd0, r_exccode, 2'd0};
      5'd14:   cp0_rdata = r_epc;
      5'd15:   cp0_rdata = PRID_VAL;
      default: cp0_rdata = 32'd0;
    endcase
  end

  assign epc_out = r_epc;

  // Mode sequencing and register updates; a trap always beats eret and mtc0,
  // and a nested exception inside the handler keeps the original EPC/BD.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_RUN;
      r_im      <= 6'd0;
      r_ie      <= 1'b0;
      r_ip      <= 6'd0;
      r_exccode <= 5'd0;
      r_bd      <= 1'b0;
      r_epc     <= 32'd0;
    end else begin
      r_ip <= hwint;
      if (w_trap) begin
        r_exccode <= w_takeInt ? 5'd0 : exc_code_m;
        if (r_state != ST_HANDLER) begin
          r_epc <= {w_epcCapture[31:2], 2'b00};
          r_bd  <= w_bdCapture;
        end
        r_state <= ST_HANDLER;
      end else begin
        if (r_state == ST_RETURN) begin
          r_state <= ST_RUN;
        end
        if (w_eret) begin
          r_state <= (r_state == ST_HANDLER) ? ST_RETURN : ST_RUN;
        end
        if (cp0_we) begin
          case (cp0_addr)
            5'd12: begin
              r_im    <= cp0_wdata[15:10];
              r_ie    <= cp0_wdata[0];
              r_state <= cp0_wdata[1] ? ST_HANDLER : ST_RUN;
            end
            5'd14:   r_epc <= {cp0_wdata[31:2], 2'b00};
            default: ;
          endcase
        end
      end
    end
  end

endmodule
